alu_req_driver: RTL and testbench
=================================

ALU_REQ_DRIVER -- requirements
Module: alu_req_driver

Interface
REQ-001 Parameter DW, default 8, operand width.
REQ-002 Parameter CW, default 4, command width.
REQ-003 Parameter MUL_LAT, default 3, cycles from final issue to response capture for MODE=1 CMD 9/10.
REQ-004 Parameter TMO, default 16, operand gap at or above which a split request is flagged as timed out.
REQ-005 CLK  in  1  sole clock; all state updates on rising edge.
REQ-006 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-007 REQ_VALID  in  1  upstream request valid.
REQ-008 REQ_READY  out  1  driver idle, request accepted when REQ_VALID && REQ_READY.
REQ-009 REQ_OPA / REQ_OPB  in  DW each  operands.
REQ-010 REQ_CMD  in  CW, REQ_MODE  in  1, REQ_CIN  in  1  operation fields.
REQ-011 REQ_SPLIT  in  2  00/11 both operands together, 01 A first then B, 10 B first then A.
REQ-012 REQ_GAP  in  5  idle cycles between halves of a split request.
REQ-013 OPA / OPB  out  DW, CMD  out  CW, MODE  out  1, CIN  out  1  ALU operand/command drive.
REQ-014 INP_VALID  out  2  ALU operand-valid code (01 A, 10 B, 11 both, 00 none).
REQ-015 CE  out  1  ALU clock enable.
REQ-016 RES  in  DW+1, COUT/OFLOW/G/E/L/ERR  in  1 each  ALU results.
REQ-017 RSP_VALID  out  1  one-cycle response strobe.
REQ-018 RSP_RES  out  DW+1, RSP_COUT/RSP_OFLOW/RSP_G/RSP_E/RSP_L/RSP_ERR  out  1 each  captured ALU results.
REQ-019 RSP_TMO  out  1  request issued with gap >= TMO.

Function
REQ-020 States IDLE, ISSUE1, GAP, ISSUE2, WAIT, RESP; all outputs registered.
REQ-021 IDLE: REQ_READY=1, CE=0, INP_VALID=00; on acceptance latch all REQ_* fields, REQ_READY=0, go ISSUE1.
REQ-022 ISSUE1 (one cycle): CE=1; OPA/OPB/CMD/MODE/CIN driven from latched fields; INP_VALID=11 for split 00/11, 01 for split 01, 10 for split 10.
REQ-023 From ISSUE1: split 00/11 -> WAIT; split 01/10 with gap 0 -> ISSUE2; else -> GAP with counter loaded to REQ_GAP.
REQ-024 GAP: INP_VALID=00, CE=1, operand/command outputs held; counter decrements each cycle; at count 1 -> ISSUE2 (exactly REQ_GAP cycles of INP_VALID=00).
REQ-025 ISSUE2 (one cycle): INP_VALID=10 for split 01, 01 for split 10; CE=1; then WAIT.
REQ-026 WAIT: INP_VALID=00, CE=1; latency counter = MUL_LAT if latched MODE=1 and CMD in {9,10}, else 1; -> RESP when expired.
REQ-027 RESP (one cycle): capture RES and flags exactly as sampled (including X/Z) into RSP_*; RSP_VALID=1; CE=1; then IDLE.
REQ-028 RSP_TMO=1 with RSP_VALID iff split is 01/10 and latched gap >= TMO; else 0.
REQ-029 RSP_* hold value until next RESP; RSP_VALID low in every other state.
REQ-030 REQ_VALID while not IDLE ignored; no queuing, back-to-back requests have one IDLE cycle minimum between RESP and next ISSUE1.
REQ-031 Request changes after acceptance have no effect on the in-flight operation.

Reset
REQ-032 RST_N low: state IDLE, REQ_READY=1, CE=0, INP_VALID=00, OPA/OPB/CMD/MODE/CIN=0, all counters 0, RSP_VALID=0, RSP_* =0, RSP_TMO=0.
REQ-033 Reset mid-operation aborts immediately; no RSP_VALID for the aborted request; first post-reset request behaves as from power-up.

Verification
REQ-034 Split 00, MODE=1, CMD=0, A=8'hFF, B=8'h01 -> ISSUE1 INP_VALID=11 one cycle, RSP_VALID 2 cycles later, RSP_RES=9'h100, RSP_COUT=1, RSP_TMO=0.
REQ-035 Split 01, gap 3, MODE=0, CMD=0, A=8'hF0, B=8'h3C -> INP_VALID 01, 00,00,00, 10; RSP_RES=9'h030.
REQ-036 Split 10, gap 16 -> 16 cycles INP_VALID=00 between 10 and 01; RSP_TMO=1.
REQ-037 MODE=1 CMD=9, A=2, B=3 -> RSP_VALID MUL_LAT+1 cycles after ISSUE1 edge, RSP_RES captured as sampled.
REQ-038 RST_N low during GAP of a split request -> outputs to reset values asynchronously, no RSP_VALID; next request completes normally.
REQ-039 REQ_VALID held high continuously -> REQ_READY high only in IDLE; each request yields exactly one RSP_VALID.

Source files
------------

// File: rtl/alu_req_driver.sv
// ---------------------------------------------------------------------------
// alu_req_driver
//
// Purpose:
//   Accepts one ALU request at a time from an upstream valid/ready port and
//   replays it onto an ALU operand/command interface. Operands may be issued
//   together or split into two halves (A then B, or B then A) separated by a
//   programmable number of idle cycles. After the final issue the driver
//   waits a command-dependent latency, captures the ALU results into a set of
//   response registers and pulses RSP_VALID for one cycle.
//
// Parameters:
//   DW       operand width
//   CW       command width
//   MUL_LAT  cycles from final issue to response capture for MODE=1 CMD 9/10
//   TMO      operand gap at or above which a split request is flagged
//
// Ports:
//   CLK, RST_N                  clock, asynchronous active-low reset
//   REQ_VALID / REQ_READY       upstream handshake (READY only while idle)
//   REQ_OPA, REQ_OPB            request operands
//   REQ_CMD, REQ_MODE, REQ_CIN  request operation fields
//   REQ_SPLIT                   00/11 together, 01 A first, 10 B first
//   REQ_GAP                     idle cycles between the two halves
//   OPA, OPB, CMD, MODE, CIN    registered ALU drive
//   INP_VALID                   ALU operand-valid code (01 A, 10 B, 11 both)
//   CE                          ALU clock enable, high while a request runs
//   RES, COUT..ERR              ALU results
//   RSP_VALID                   one-cycle response strobe
//   RSP_RES, RSP_COUT..RSP_ERR  captured ALU results, held until next capture
//   RSP_TMO                     response belongs to a split with gap >= TMO
// ---------------------------------------------------------------------------
module alu_req_driver #(
    parameter int DW      = 8,
    parameter int CW      = 4,
    parameter int MUL_LAT = 3,
    parameter int TMO     = 16
) (
    input  logic          CLK,
    input  logic          RST_N,

    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic [DW-1:0] REQ_OPA,
    input  logic [DW-1:0] REQ_OPB,
    input  logic [CW-1:0] REQ_CMD,
    input  logic          REQ_MODE,
    input  logic          REQ_CIN,
    input  logic [1:0]    REQ_SPLIT,
    input  logic [4:0]    REQ_GAP,

    output logic [DW-1:0] OPA,
    output logic [DW-1:0] OPB,
    output logic [CW-1:0] CMD,
    output logic          MODE,
    output logic          CIN,
    output logic [1:0]    INP_VALID,
    output logic          CE,

    input  logic [DW:0]   RES,
    input  logic          COUT,
    input  logic          OFLOW,
    input  logic          G,
    input  logic          E,
    input  logic          L,
    input  logic          ERR,

    output logic          RSP_VALID,
    output logic [DW:0]   RSP_RES,
    output logic          RSP_COUT,
    output logic          RSP_OFLOW,
    output logic          RSP_G,
    output logic          RSP_E,
    output logic          RSP_L,
    output logic          RSP_ERR,
    output logic          RSP_TMO
);

    // A latency of zero makes no sense for a counted wait, so it is clamped
    // to one; the counter is sized to hold the clamped value.
    localparam int          MUL_EFF = (MUL_LAT < 1) ? 1 : MUL_LAT;
    localparam int          LAT_W   = $clog2(MUL_EFF + 1);
    localparam logic [31:0] TMO_U   = 32'(TMO);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE1,
        S_GAP,
        S_ISSUE2,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_q;
    logic [1:0]       split_q;
    logic [4:0]       gap_q;
    logic             tmo_q;
    logic [4:0]       gap_cnt;
    logic [LAT_W-1:0] lat_cnt;

    logic             req_is_split;
    logic [1:0]       req_first_code;
    logic             req_tmo;
    logic             is_split_q;
    logic [1:0]       second_code;
    logic             mul_cmd;
    logic [LAT_W-1:0] wait_lat;

    // Decode of the incoming request, used only on the acceptance edge.
    // Split codes 01 and 10 are real splits; 00 and 11 both mean "issue
    // both operands at once", so the first code collapses to 11 for them.
    assign req_is_split   = REQ_SPLIT[0] ^ REQ_SPLIT[1];
    assign req_first_code = req_is_split ? REQ_SPLIT : 2'b11;
    assign req_tmo        = req_is_split && ({27'd0, REQ_GAP} >= TMO_U);

    // The second half of a split issues the other operand, which is simply
    // the latched split code with its two bits swapped.
    assign is_split_q  = split_q[0] ^ split_q[1];
    assign second_code = {split_q[0], split_q[1]};

    // Multiply-class commands take longer in the ALU. MODE/CMD outputs are
    // loaded on acceptance and held for the whole operation, so they double
    // as the latched copy of the request fields.
    assign mul_cmd  = MODE && ((CMD == CW'(9)) || (CMD == CW'(10)));
    assign wait_lat = mul_cmd ? LAT_W'(MUL_EFF) : LAT_W'(1);

    // Single sequencer: every output is a register updated on the edge that
    // enters the state it belongs to, so the ALU sees clean, glitch-free
    // drive. Reset aborts any operation in flight without a response.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            split_q   <= 2'b00;
            gap_q     <= 5'd0;
            tmo_q     <= 1'b0;
            gap_cnt   <= 5'd0;
            lat_cnt   <= '0;
            REQ_READY <= 1'b1;
            OPA       <= '0;
            OPB       <= '0;
            CMD       <= '0;
            MODE      <= 1'b0;
            CIN       <= 1'b0;
            INP_VALID <= 2'b00;
            CE        <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_RES   <= '0;
            RSP_COUT  <= 1'b0;
            RSP_OFLOW <= 1'b0;
            RSP_G     <= 1'b0;
            RSP_E     <= 1'b0;
            RSP_L     <= 1'b0;
            RSP_ERR   <= 1'b0;
            RSP_TMO   <= 1'b0;
        end else begin
            case (state_q)
                // Waiting for work. All request fields are captured here so
                // later changes on the request port cannot disturb the run.
                S_IDLE: begin
                    if (REQ_VALID) begin
                        OPA       <= REQ_OPA;
                        OPB       <= REQ_OPB;
                        CMD       <= REQ_CMD;
                        MODE      <= REQ_MODE;
                        CIN       <= REQ_CIN;
                        split_q   <= REQ_SPLIT;
                        gap_q     <= REQ_GAP;
                        tmo_q     <= req_tmo;
                        INP_VALID <= req_first_code;
                        CE        <= 1'b1;
                        REQ_READY <= 1'b0;
                        state_q   <= S_ISSUE1;
                    end
                end

                // First (or only) issue lasts exactly one cycle. A split with
                // a zero gap goes straight to the second issue.
                S_ISSUE1: begin
                    if (!is_split_q) begin
                        INP_VALID <= 2'b00;
                        lat_cnt   <= wait_lat;
                        state_q   <= S_WAIT;
                    end else if (gap_q == 5'd0) begin
                        INP_VALID <= second_code;
                        state_q   <= S_ISSUE2;
                    end else begin
                        INP_VALID <= 2'b00;
                        gap_cnt   <= gap_q;
                        state_q   <= S_GAP;
                    end
                end

                // Idle cycles between halves. The counter is loaded with the
                // gap and this state is left when it reaches one, giving
                // exactly gap cycles with no operand valid.
                S_GAP: begin
                    if (gap_cnt <= 5'd1) begin
                        gap_cnt   <= 5'd0;
                        INP_VALID <= second_code;
                        state_q   <= S_ISSUE2;
                    end else begin
                        gap_cnt <= gap_cnt - 5'd1;
                    end
                end

                // Second half of a split, one cycle.
                S_ISSUE2: begin
                    INP_VALID <= 2'b00;
                    lat_cnt   <= wait_lat;
                    state_q   <= S_WAIT;
                end

                // Let the ALU settle for the command's latency, then capture
                // its outputs verbatim on the edge that enters RESP.
                S_WAIT: begin
                    if (lat_cnt <= LAT_W'(1)) begin
                        lat_cnt   <= '0;
                        RSP_VALID <= 1'b1;
                        RSP_RES   <= RES;
                        RSP_COUT  <= COUT;
                        RSP_OFLOW <= OFLOW;
                        RSP_G     <= G;
                        RSP_E     <= E;
                        RSP_L     <= L;
                        RSP_ERR   <= ERR;
                        RSP_TMO   <= tmo_q;
                        state_q   <= S_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end

                // Response strobe is a single cycle. The captured results stay
                // put; only the strobe and timeout flag drop. Returning to
                // IDLE forces at least one idle cycle before the next issue.
                S_RESP: begin
                    RSP_VALID <= 1'b0;
                    RSP_TMO   <= 1'b0;
                    CE        <= 1'b0;
                    REQ_READY <= 1'b1;
                    state_q   <= S_IDLE;
                end

                default: begin
                    state_q   <= S_IDLE;
                    INP_VALID <= 2'b00;
                    CE        <= 1'b0;
                    RSP_VALID <= 1'b0;
                    RSP_TMO   <= 1'b0;
                    REQ_READY <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_driver.sv
// ---------------------------------------------------------------------------
// tb_alu_req_driver
//
// Purpose:
//   Directed self-checking bench for alu_req_driver with default parameters
//   (DW=8, CW=4, MUL_LAT=3, TMO=16). A small behavioural ALU answers the
//   driver's operand/command outputs; every expected value is a hand-computed
//   constant in the stimulus calls below.
// ---------------------------------------------------------------------------
module tb_alu_req_driver;

    logic       CLK;
    logic       RST_N;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [7:0] REQ_OPA;
    logic [7:0] REQ_OPB;
    logic [3:0] REQ_CMD;
    logic       REQ_MODE;
    logic       REQ_CIN;
    logic [1:0] REQ_SPLIT;
    logic [4:0] REQ_GAP;
    logic [7:0] OPA;
    logic [7:0] OPB;
    logic [3:0] CMD;
    logic       MODE;
    logic       CIN;
    logic [1:0] INP_VALID;
    logic       CE;
    logic [8:0] RES;
    logic       COUT, OFLOW, G, E, L, ERR;
    logic       RSP_VALID;
    logic [8:0] RSP_RES;
    logic       RSP_COUT, RSP_OFLOW, RSP_G, RSP_E, RSP_L, RSP_ERR, RSP_TMO;

    int         compareCount;
    int         mismatchCount;
    int         rspCount;
    logic [1:0] trace[$];

    alu_req_driver dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_OPA   (REQ_OPA),
        .REQ_OPB   (REQ_OPB),
        .REQ_CMD   (REQ_CMD),
        .REQ_MODE  (REQ_MODE),
        .REQ_CIN   (REQ_CIN),
        .REQ_SPLIT (REQ_SPLIT),
        .REQ_GAP   (REQ_GAP),
        .OPA       (OPA),
        .OPB       (OPB),
        .CMD       (CMD),
        .MODE      (MODE),
        .CIN       (CIN),
        .INP_VALID (INP_VALID),
        .CE        (CE),
        .RES       (RES),
        .COUT      (COUT),
        .OFLOW     (OFLOW),
        .G         (G),
        .E         (E),
        .L         (L),
        .ERR       (ERR),
        .RSP_VALID (RSP_VALID),
        .RSP_RES   (RSP_RES),
        .RSP_COUT  (RSP_COUT),
        .RSP_OFLOW (RSP_OFLOW),
        .RSP_G     (RSP_G),
        .RSP_E     (RSP_E),
        .RSP_L     (RSP_L),
        .RSP_ERR   (RSP_ERR),
        .RSP_TMO   (RSP_TMO)
    );

    // 10-unit clock period.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Minimal ALU stand-in: MODE=1 CMD0 add, CMD9 (A+1)*(B+1), CMD10 A*B;
    // MODE=0 CMD0 bitwise AND. Compare flags always follow the operands.
    always_comb begin
        RES   = '0;
        COUT  = 1'b0;
        OFLOW = 1'b0;
        ERR   = 1'b0;
        G     = (OPA > OPB);
        E     = (OPA == OPB);
        L     = (OPA < OPB);
        if (MODE) begin
            case (CMD)
                4'd0: begin
                    RES   = {1'b0, OPA} + {1'b0, OPB};
                    COUT  = RES[8];
                    OFLOW = (OPA[7] == OPB[7]) && (RES[7] != OPA[7]);
                end
                4'd9:    RES = ({1'b0, OPA} + 9'd1) * ({1'b0, OPB} + 9'd1);
                4'd10:   RES = {1'b0, OPA} * {1'b0, OPB};
                default: ERR = 1'b1;
            endcase
        end else begin
            case (CMD)
                4'd0:    RES = {1'b0, OPA & OPB};
                default: RES = '0;
            endcase
        end
    end

    // Running count of response strobes, used to prove an aborted request
    // never responds.
    always @(negedge CLK) begin
        if (RSP_VALID === 1'b1) rspCount++;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one request for a single clock edge, then scramble the request
    // port so any dependence on live request fields shows up. Leaves the bench
    // at the sample point of the first issue cycle.
    task automatic applyStimulus(input string tag, input logic [1:0] split,
                                 input logic [4:0] gap, input logic mode,
                                 input logic [3:0] cmd, input logic [7:0] a,
                                 input logic [7:0] b, input logic cin);
        REQ_SPLIT = split;
        REQ_GAP   = gap;
        REQ_MODE  = mode;
        REQ_CMD   = cmd;
        REQ_OPA   = a;
        REQ_OPB   = b;
        REQ_CIN   = cin;
        REQ_VALID = 1'b1;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        REQ_SPLIT = ~split;
        REQ_GAP   = ~gap;
        REQ_MODE  = ~mode;
        REQ_CMD   = ~cmd;
        REQ_OPA   = ~a;
        REQ_OPB   = ~b;
        REQ_CIN   = ~cin;
        checkOutput($sformatf("%s_ready_busy", tag), REQ_READY, 0);
        checkOutput($sformatf("%s_ce_issue", tag), CE, 1);
        checkOutput($sformatf("%s_opa", tag), OPA, a);
        checkOutput($sformatf("%s_opb", tag), OPB, b);
        checkOutput($sformatf("%s_cin", tag), CIN, cin);
    endtask

    // Record INP_VALID each cycle until the response strobe, bounded.
    // idx is the 1-based sample number of the strobe (0 if it never came).
    task automatic traceToResponse(output int idx);
        idx = 0;
        trace.delete();
        for (int k = 1; k <= 80; k++) begin
            if (RSP_VALID === 1'b1) begin
                idx = k;
                break;
            end
            trace.push_back(INP_VALID);
            @(negedge CLK);
        end
    endtask

    task automatic expectTrace(input string tag, input logic [1:0] first,
                               input logic [1:0] second, input int gap,
                               input int lat, input int expIdx, input int gotIdx);
        logic [1:0]  expSeq[$];
        logic [31:0] missing;
        missing = 'x;
        expSeq.push_back(first);
        if (second != 2'b00) begin
            for (int i = 0; i < gap; i++) expSeq.push_back(2'b00);
            expSeq.push_back(second);
        end
        for (int i = 0; i < lat; i++) expSeq.push_back(2'b00);
        checkOutput($sformatf("%s_rsp_cycle", tag), gotIdx, expIdx);
        for (int i = 0; i < expSeq.size(); i++) begin
            if (i < trace.size())
                checkOutput($sformatf("%s_inp%0d", tag, i), trace[i], expSeq[i]);
            else
                checkOutput($sformatf("%s_inp%0d", tag, i), missing, expSeq[i]);
        end
    endtask

    task automatic finishResponse(input string tag);
        @(negedge CLK);
        checkOutput($sformatf("%s_valid_drop", tag), RSP_VALID, 0);
        checkOutput($sformatf("%s_ready_idle", tag), REQ_READY, 1);
        checkOutput($sformatf("%s_ce_idle", tag), CE, 0);
        checkOutput($sformatf("%s_tmo_drop", tag), RSP_TMO, 0);
    endtask

    task automatic runCase(input string tag, input logic [1:0] split,
                           input logic [4:0] gap, input logic mode,
                           input logic [3:0] cmd, input logic [7:0] a,
                           input logic [7:0] b, input logic cin,
                           input logic [1:0] first, input logic [1:0] second,
                           input int lat, input int expIdx,
                           input logic [8:0] expRes, input logic expTmo,
                           input logic expCout);
        int idx;
        applyStimulus(tag, split, gap, mode, cmd, a, b, cin);
        traceToResponse(idx);
        expectTrace(tag, first, second, int'(gap), lat, expIdx, idx);
        checkOutput($sformatf("%s_res", tag), RSP_RES, expRes);
        checkOutput($sformatf("%s_tmo", tag), RSP_TMO, expTmo);
        checkOutput($sformatf("%s_cout", tag), RSP_COUT, expCout);
        finishResponse(tag);
    endtask

    initial begin
        int rspBefore;
        int readyCnt;
        int pulseCnt;
        int badCnt;
        compareCount  = 0;
        mismatchCount = 0;
        rspCount      = 0;
        RST_N     = 1'b1;
        REQ_VALID = 1'b0;
        REQ_OPA   = '0;
        REQ_OPB   = '0;
        REQ_CMD   = '0;
        REQ_MODE  = 1'b0;
        REQ_CIN   = 1'b0;
        REQ_SPLIT = 2'b00;
        REQ_GAP   = 5'd0;

        // Power-up reset, checked before any clock edge.
        #1 RST_N = 1'b0;
        #1;
        checkOutput("rst_ready", REQ_READY, 1);
        checkOutput("rst_ce", CE, 0);
        checkOutput("rst_inp_valid", INP_VALID, 0);
        checkOutput("rst_opa", OPA, 0);
        checkOutput("rst_rsp_valid", RSP_VALID, 0);
        checkOutput("rst_rsp_res", RSP_RES, 0);
        checkOutput("rst_rsp_tmo", RSP_TMO, 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        //        tag         split  gap    md  cmd    A      B      cin   first  second lat idx res     tmo cout
        runCase("add_both",   2'b00, 5'd0,  1, 4'd0,  8'hFF, 8'h01, 1'b0, 2'b11, 2'b00, 1,  3, 9'h100, 0,  1);
        checkOutput("add_both_g_held", RSP_G, 1);
        checkOutput("add_both_l_held", RSP_L, 0);
        checkOutput("add_both_e_held", RSP_E, 0);
        checkOutput("add_both_ofl_held", RSP_OFLOW, 0);
        checkOutput("add_both_res_held", RSP_RES, 9'h100);
        runCase("and_gap3",   2'b01, 5'd3,  0, 4'd0,  8'hF0, 8'h3C, 1'b1, 2'b01, 2'b10, 1,  7, 9'h030, 0,  0);
        runCase("and_gap16",  2'b10, 5'd16, 0, 4'd0,  8'h0F, 8'hFF, 1'b0, 2'b10, 2'b01, 1, 20, 9'h00F, 1,  0);
        runCase("and_gap15",  2'b01, 5'd15, 0, 4'd0,  8'hAA, 8'h0F, 1'b0, 2'b01, 2'b10, 1, 19, 9'h00A, 0,  0);
        runCase("add_gap0",   2'b01, 5'd0,  1, 4'd0,  8'h03, 8'h05, 1'b0, 2'b01, 2'b10, 1,  4, 9'h008, 0,  0);
        runCase("mul9",       2'b00, 5'd0,  1, 4'd9,  8'h02, 8'h03, 1'b0, 2'b11, 2'b00, 3,  5, 9'h00C, 0,  0);
        runCase("mul10_s11",  2'b11, 5'd0,  1, 4'd10, 8'h04, 8'h05, 1'b0, 2'b11, 2'b00, 3,  5, 9'h014, 0,  0);
        runCase("mode0_cmd9", 2'b00, 5'd0,  0, 4'd9,  8'h02, 8'h03, 1'b0, 2'b11, 2'b00, 1,  3, 9'h000, 0,  0);
        runCase("mul9_split", 2'b10, 5'd2,  1, 4'd9,  8'h01, 8'h01, 1'b0, 2'b10, 2'b01, 3,  8, 9'h004, 0,  0);

        // Reset asserted in the middle of a split gap.
        applyStimulus("abort", 2'b01, 5'd8, 1'b1, 4'd0, 8'h11, 8'h22, 1'b1);
        repeat (2) @(negedge CLK);
        rspBefore = rspCount;
        #2 RST_N = 1'b0;
        #1;
        checkOutput("abort_ready", REQ_READY, 1);
        checkOutput("abort_ce", CE, 0);
        checkOutput("abort_inp_valid", INP_VALID, 0);
        checkOutput("abort_opa", OPA, 0);
        checkOutput("abort_opb", OPB, 0);
        checkOutput("abort_mode", MODE, 0);
        checkOutput("abort_cin", CIN, 0);
        checkOutput("abort_rsp_res", RSP_RES, 0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (20) @(negedge CLK);
        checkOutput("abort_no_rsp", rspCount, rspBefore);
        runCase("post_rst",   2'b00, 5'd0,  1, 4'd0,  8'h11, 8'h22, 1'b0, 2'b11, 2'b00, 1,  3, 9'h033, 0,  0);

        // Request held valid: every fourth cycle is idle and yields one response.
        readyCnt  = 0;
        pulseCnt  = 0;
        badCnt    = 0;
        REQ_SPLIT = 2'b00;
        REQ_GAP   = 5'd0;
        REQ_MODE  = 1'b0;
        REQ_CMD   = 4'd0;
        REQ_OPA   = 8'h05;
        REQ_OPB   = 8'h03;
        REQ_VALID = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (REQ_READY === 1'b1) readyCnt++;
            if (RSP_VALID === 1'b1) pulseCnt++;
            if ((REQ_READY === 1'b1) && ((CE !== 1'b0) || (INP_VALID !== 2'b00))) badCnt++;
        end
        REQ_VALID = 1'b0;
        checkOutput("stream_ready_cycles", readyCnt, 10);
        checkOutput("stream_responses", pulseCnt, 10);
        checkOutput("stream_ready_busy", badCnt, 0);
        checkOutput("stream_res", RSP_RES, 9'h001);
        @(negedge CLK);
        checkOutput("stream_end_ready", REQ_READY, 1);
        checkOutput("stream_end_ce", CE, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
